// File: rtl/alu_pkg.sv
// Shared opcode encoding for the execute-stage ALU and anything that drives it.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SRA = 4'd10,
        OP_CMP = 4'd11
    } alu_op_t;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider, one subtract stage per quotient bit.
// Divide-by-zero yields an all-ones quotient and returns the dividend as remainder.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quot_raw;
    logic             b_zero;

    assign b_zero = (b == '0);

    // Stage gi brings in dividend bit WIDTH-1-gi and tries one subtraction.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        logic [WIDTH-1:0] rem_in;
        logic [WIDTH:0]   partial;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] rem_out;

        if (gi == 0) begin : g_first
            assign rem_in = '0;
        end else begin : g_next
            assign rem_in = g_stage[gi-1].rem_out;
        end

        assign partial = {rem_in, a[WIDTH-1-gi]};
        assign diff    = partial - {1'b0, b};
        assign quot_raw[WIDTH-1-gi] = ~diff[WIDTH];
        assign rem_out = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    assign quotient  = b_zero ? '1 : quot_raw;
    assign remainder = b_zero ? a  : g_stage[WIDTH-1].rem_out;

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: one operation per clock, primary and secondary
// results registered with a single cycle of latency.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               carryin,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   extra
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   out_reg, out_next;
    logic [WIDTH-1:0]   extra_reg, extra_next;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_q, div_r;
    logic [SHW-1:0]     sh;
    logic               eq, slt, ult;

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .a         (a),
        .b         (b),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Top bit of the widened difference is the borrow out of a - b - carryin.
    assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryin};
    assign sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carryin};
    assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign sh       = b[SHW-1:0];
    assign eq       = (a == b);
    assign ult      = (a < b);
    assign slt      = ($signed(a) < $signed(b));

    always_comb begin
        out_next   = '0;
        extra_next = '0;
        case (opcode)
            OP_ADD: begin
                out_next   = add_sum[WIDTH-1:0];
                extra_next = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            end
            OP_SUB: begin
                out_next   = sub_diff[WIDTH-1:0];
                extra_next = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
            end
            OP_MUL: begin
                out_next   = prod[WIDTH-1:0];
                extra_next = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                out_next   = div_q;
                extra_next = div_r;
            end
            OP_AND: out_next = a & b;
            OP_OR:  out_next = a | b;
            OP_XOR: out_next = a ^ b;
            OP_NOT: out_next = ~a;
            OP_SHL: out_next = a << sh;
            OP_SHR: out_next = a >> sh;
            OP_SRA: out_next = $signed(a) >>> sh;
            OP_CMP: begin
                out_next   = {{(WIDTH-2){1'b0}}, eq, slt};
                extra_next = {{(WIDTH-2){1'b0}}, eq, ult};
            end
            default: begin
                out_next   = '0;
                extra_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            extra_reg <= '0;
        end else begin
            out_reg   <= out_next;
            extra_reg <= extra_next;
        end
    end

    assign out   = out_reg;
    assign extra = extra_reg;

endmodule

// File: tb/tb_alu.sv
// Randomised bench for alu (WIDTH=32): arithmetic reference model checked every
// live cycle, plus directed literal cases that pin the model itself.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [3:0]   opcode;
    logic [W-1:0] a, b;
    logic         carryin;
    logic [W-1:0] out, extra;

    int checks;
    int fails;

    alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .carryin (carryin),
        .out     (out),
        .extra   (extra)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] o, output logic [W-1:0] e);
        logic [63:0] w;
        int unsigned s;
        s = int'(y % 32);
        o = '0;
        e = '0;
        case (op)
            4'd0: begin
                w = 64'(x) + 64'(y) + 64'(c);
                o = w[31:0];
                e = (w >= 64'h1_0000_0000) ? 32'd1 : 32'd0;
            end
            4'd1: begin
                o = x - y - 32'(c);
                e = (64'(x) < 64'(y) + 64'(c)) ? 32'd1 : 32'd0;
            end
            4'd2: begin
                w = 64'(x) * 64'(y);
                o = w[31:0];
                e = w[63:32];
            end
            4'd3: begin
                if (y == 0) begin
                    o = 32'hFFFF_FFFF;
                    e = x;
                end else begin
                    o = x / y;
                    e = x % y;
                end
            end
            4'd4: o = x & y;
            4'd5: o = x | y;
            4'd6: o = x ^ y;
            4'd7: o = ~x;
            4'd8: o = x << s;
            4'd9: o = x >> s;
            4'd10: o = 32'($signed(x) >>> s);
            4'd11: begin
                o = (x == y ? 32'd2 : 32'd0) + ($signed(x) < $signed(y) ? 32'd1 : 32'd0);
                e = (x == y ? 32'd2 : 32'd0) + (x < y ? 32'd1 : 32'd0);
            end
            default: begin
                o = '0;
                e = '0;
            end
        endcase
    endfunction

    // Compare process: every edge taken out of reset must produce the model's result.
    logic [W-1:0] cmp_eo, cmp_ee;
    logic [3:0]   cmp_op;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_live;
    always @(posedge clk) begin
        cmp_live = rst_n;
        cmp_op   = opcode;
        cmp_a    = a;
        cmp_b    = b;
        model(opcode, a, b, carryin, cmp_eo, cmp_ee);
        #1;
        if (cmp_live && rst_n) begin
            $display("op=%0d a=%h b=%h -> out=%h extra=%h", cmp_op, cmp_a, cmp_b, out, extra);
            chk("model_out", out, cmp_eo);
            chk("model_extra", extra, cmp_ee);
        end
    end

    task automatic drive(input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic c);
        @(negedge clk);
        opcode  = op;
        a       = x;
        b       = y;
        carryin = c;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic c,
                            input logic [W-1:0] eo, input logic [W-1:0] ee);
        drive(op, x, y, c);
        @(posedge clk);
        #1;
        chk({name, "_out"}, out, eo);
        chk({name, "_extra"}, extra, ee);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        checks  = 0;
        fails   = 0;
        rst_n   = 1'b0;
        opcode  = '0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, '0);
        chk("reset_extra", extra, '0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add0", OP_ADD, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 32'h0);
        directed("add1", OP_ADD, 32'h66666666, 32'h66666666, 1'b1, 32'hCCCCCCCD, 32'h0);
        directed("add2", OP_ADD, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        32'h1);
        directed("sub0", OP_SUB, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h55555555, 32'h0);
        directed("sub1", OP_SUB, 32'h66666666, 32'h66666666, 1'b1, 32'hFFFFFFFF, 32'h1);
        directed("mul",  OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        directed("div",  OP_DIV, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h2,        32'h0);
        directed("div0", OP_DIV, 32'h1234,     32'h0,        1'b1, 32'hFFFFFFFF, 32'h1234);
        directed("and",  OP_AND, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h0,        32'h0);
        directed("or",   OP_OR,  32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 32'h0);
        directed("xor",  OP_XOR, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 32'h0);
        directed("not",  OP_NOT, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h55555555, 32'h0);
        directed("shl",  OP_SHL, 32'h80000000, 32'h4,        1'b0, 32'h0,        32'h0);
        directed("shr",  OP_SHR, 32'h80000000, 32'h4,        1'b0, 32'h08000000, 32'h0);
        directed("sra",  OP_SRA, 32'h80000000, 32'h4,        1'b1, 32'hF8000000, 32'h0);
        directed("cmp0", OP_CMP, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h1,        32'h0);
        directed("cmp1", OP_CMP, 32'h12345678, 32'h12345678, 1'b0, 32'h2,        32'h2);
        for (int op = 12; op < 16; op++)
            directed("rsvd", 4'(op), 32'hDEADBEEF, 32'h1, 1'b1, 32'h0, 32'h0);

        // Asynchronous reset in the low phase: outputs must clear with no edge.
        drive(OP_OR, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_out", out, 32'hFFFFFFFF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", out, '0);
        chk("async_reset_extra", extra, '0);
        @(posedge clk);
        #1;
        chk("reset_hold_out", out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: every opcode on consecutive cycles, checked by the model.
        for (int op = 0; op < 12; op++)
            drive(4'(op), $urandom, $urandom, 1'($urandom));

        for (int i = 0; i < 400; i++) begin
            ra = rnd_operand();
            rb = ($urandom_range(0, 7) == 0) ? ra : rnd_operand();
            drive(4'($urandom_range(0, 15)), ra, rb, 1'($urandom));
        end

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
